// File: rtl/mux_sel_ctrl_if.sv
// Button-to-select bus for mux_sel_ctrl.
// master: the side driving the raw button (board pin or bench).
// slave : the controller itself.
// auto_en exists only when AUTO_TOGGLE_EN is defined.
interface mux_sel_ctrl_if;
  logic key;
  logic key_stable;
  logic sel;
  logic sel_changed;
`ifdef AUTO_TOGGLE_EN
  logic auto_en;

  modport master (
    output key,
    output auto_en,
    input  key_stable,
    input  sel,
    input  sel_changed
  );

  modport slave (
    input  key,
    input  auto_en,
    output key_stable,
    output sel,
    output sel_changed
  );
`else
  modport master (
    output key,
    input  key_stable,
    input  sel,
    input  sel_changed
  );

  modport slave (
    input  key,
    output key_stable,
    output sel,
    output sel_changed
  );
`endif
endinterface

// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: turns a raw, bouncing push-button into the mux select line.
// key -> synchroniser -> debounce -> rising-edge detect -> toggle sel.
// sel_changed pulses for one cycle after every change of sel.
// Optional macro AUTO_TOGGLE_EN adds auto_en and a free-running period
// counter that toggles sel every AUTO_PERIOD cycles while auto_en is high.
// All outputs come straight from flops.
module mux_sel_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 16
) (
  input  logic           clk,
  input  logic           rst,
  mux_sel_ctrl_if.slave  bus
);

  localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ks;
  logic [DW-1:0]          db_cnt;
  logic                   key_stable_q;
  logic                   key_stable_d;
  logic                   sel_q;
  logic                   sel_changed_q;
  logic                   press;
  logic                   toggle;

  assign ks = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.key};
  end

  // Debounce: accept a new level only after it persists DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt       <= '0;
      key_stable_q <= 1'b0;
    end else if (ks == key_stable_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      key_stable_q <= ks;
      db_cnt       <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_stable_d <= 1'b0;
    else     key_stable_d <= key_stable_q;
  end

  assign press = key_stable_q & ~key_stable_d;

`ifdef AUTO_TOGGLE_EN
  localparam int            AW        = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] auto_cnt;
  logic          auto_wrap;

  assign auto_wrap = bus.auto_en & (auto_cnt == AUTO_LAST);

  // Period counter; a button press restarts the period so the next auto
  // toggle is a full AUTO_PERIOD after the manual one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  auto_cnt <= '0;
    else if (!bus.auto_en || press || auto_wrap) auto_cnt <= '0;
    else                                      auto_cnt <= auto_cnt + AW'(1);
  end

  // Press and wrap on the same edge merge into one toggle.
  assign toggle = press | auto_wrap;
`else
  assign toggle = press;
`endif

  // Select register and its one-cycle change pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q         <= 1'b0;
      sel_changed_q <= 1'b0;
    end else begin
      sel_changed_q <= toggle;
      if (toggle) sel_q <= ~sel_q;
    end
  end

  assign bus.key_stable  = key_stable_q;
  assign bus.sel         = sel_q;
  assign bus.sel_changed = sel_changed_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Bench for mux_sel_ctrl with default parameters (SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, AUTO_PERIOD=16). Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point.
module tb_mux_sel_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mux_sel_ctrl_if bus ();

  mux_sel_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic key;
    logic exp_ks;
    logic exp_sel;
    logic exp_chg;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic k, input logic ks, input logic s, input logic c);
    vec_t v;
    v.key = k; v.exp_ks = ks; v.exp_sel = s; v.exp_chg = c;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  int pulses;
  int press_pulses;
  int pulse_at[$];
  int sel_at[$];

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    bus.key = 1'b0;
`ifdef AUTO_TOGGLE_EN
    bus.auto_en = 1'b0;
`endif

    // Reset values
    repeat (2) step();
    check("rst.key_stable", bus.key_stable, 0);
    check("rst.sel", bus.sel, 0);
    check("rst.sel_changed", bus.sel_changed, 0);
    rst = 1'b0;

    // Bounce 1,0,1,1,0 then quiet: nothing accepted
    add(1,0,0,0); add(0,0,0,0); add(1,0,0,0); add(1,0,0,0); add(0,0,0,0);
    add(0,0,0,0); add(0,0,0,0); add(0,0,0,0); add(0,0,0,0); add(0,0,0,0);
    // Clean press: key_stable after edge 6, sel after edge 7, pulse at 7
    add(1,0,0,0); add(1,0,0,0); add(1,0,0,0); add(1,0,0,0); add(1,0,0,0);
    add(1,1,0,0); add(1,1,1,1); add(1,1,1,0); add(1,1,1,0);
    // Release: key_stable falls after 6 edges, no toggle
    add(0,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,0,1,0); add(0,0,1,0); add(0,0,1,0);

    foreach (vq[i]) begin
      bus.key = vq[i].key;
      step();
      check($sformatf("vec%0d.key_stable", i), bus.key_stable, vq[i].exp_ks);
      check($sformatf("vec%0d.sel", i), bus.sel, vq[i].exp_sel);
      check($sformatf("vec%0d.sel_changed", i), bus.sel_changed, vq[i].exp_chg);
    end

    // Reset mid-debounce with key held; sel was 1 before reset
    bus.key = 1'b1;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst.key_stable", bus.key_stable, 0);
    check("midrst.sel", bus.sel, 0);
    check("midrst.sel_changed", bus.sel_changed, 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    check("postrst.e5.key_stable", bus.key_stable, 0);
    step();
    check("postrst.e6.key_stable", bus.key_stable, 1);
    check("postrst.e6.sel", bus.sel, 0);
    step();
    check("postrst.e7.sel", bus.sel, 1);
    check("postrst.e7.sel_changed", bus.sel_changed, 1);
    step();
    check("postrst.e8.sel_changed", bus.sel_changed, 0);

    // Three clean presses from reset: sel 1,0,1 and three pulses
    bus.key = 1'b0;
    do_reset();
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      press_pulses = 0;
      bus.key = 1'b1;
      for (int c = 0; c < 20; c++) begin
        step();
        if (bus.sel_changed) press_pulses++;
      end
      check($sformatf("multi%0d.pulses", p), press_pulses, 1);
      check($sformatf("multi%0d.sel", p), bus.sel, (p % 2 == 0) ? 1 : 0);
      pulses += press_pulses;
      bus.key = 1'b0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (bus.sel_changed) pulses++;
      end
    end
    check("multi.total_pulses", pulses, 3);
    check("multi.final_sel", bus.sel, 1);

    // Long hold: one toggle only, nothing on release
    pulses  = 0;
    bus.key = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (bus.sel_changed) pulses++;
    end
    bus.key = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.sel_changed) pulses++;
    end
    check("hold.pulses", pulses, 1);
    check("hold.sel", bus.sel, 0);

`ifdef AUTO_TOGGLE_EN
    // Auto toggles every 16 edges after auto_en rises
    bus.key = 1'b0;
    do_reset();
    bus.auto_en = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      step();
      if (bus.sel_changed) pulse_at.push_back(e);
    end
    check("auto.count", pulse_at.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("auto.edge%0d", k),
            (k < pulse_at.size()) ? pulse_at[k] : -1, 16 * (k + 1));
    check("auto.sel64", bus.sel, 0);

    // Press lands on the wrap at edge 80: single toggle, next wrap at 96
    pulse_at.delete();
    for (int e = 65; e <= 96; e++) begin
      if (e == 74) bus.key = 1'b1;
      step();
      if (bus.sel_changed) begin
        pulse_at.push_back(e);
        sel_at.push_back(int'(bus.sel));
      end
    end
    check("coinc.count", pulse_at.size(), 2);
    check("coinc.edge0", (pulse_at.size() > 0) ? pulse_at[0] : -1, 80);
    check("coinc.sel0", (sel_at.size() > 0) ? sel_at[0] : -1, 1);
    check("coinc.edge1", (pulse_at.size() > 1) ? pulse_at[1] : -1, 96);
    bus.auto_en = 1'b0;
    bus.key     = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
